// File: rtl/fb_mem_arbiter_if.sv
// Bus bundle between the display/gfx front ends, the framebuffer arbiter and the SRAM controller.
// slave is the arbiter's view; master is the surrounding requesters plus memory.
interface fb_mem_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 16
);

  // Display read request and read-data return
  logic                  disp_rd_valid;
  logic                  disp_rd_ready;
  logic [ADDR_WIDTH-1:0] disp_rd_addr;
  logic                  disp_rd_data_valid;
  logic [DATA_WIDTH-1:0] disp_rd_data;

  // Gfx write request
  logic                  gfx_wr_valid;
  logic                  gfx_wr_ready;
  logic [ADDR_WIDTH-1:0] gfx_wr_addr;
  logic [DATA_WIDTH-1:0] gfx_wr_data;

  // Memory command port and read return
  logic                  mem_cmd_valid;
  logic                  mem_cmd_ready;
  logic                  mem_cmd_we;
  logic [ADDR_WIDTH-1:0] mem_cmd_addr;
  logic [DATA_WIDTH-1:0] mem_cmd_wdata;
  logic                  mem_rd_valid;
  logic [DATA_WIDTH-1:0] mem_rd_data;

  modport slave (
    input  disp_rd_valid, disp_rd_addr,
    output disp_rd_ready, disp_rd_data_valid, disp_rd_data,
    input  gfx_wr_valid, gfx_wr_addr, gfx_wr_data,
    output gfx_wr_ready,
    output mem_cmd_valid, mem_cmd_we, mem_cmd_addr, mem_cmd_wdata,
    input  mem_cmd_ready, mem_rd_valid, mem_rd_data
  );

  modport master (
    output disp_rd_valid, disp_rd_addr,
    input  disp_rd_ready, disp_rd_data_valid, disp_rd_data,
    output gfx_wr_valid, gfx_wr_addr, gfx_wr_data,
    input  gfx_wr_ready,
    input  mem_cmd_valid, mem_cmd_we, mem_cmd_addr, mem_cmd_wdata,
    output mem_cmd_ready, mem_rd_valid, mem_rd_data
  );

endinterface

// File: rtl/fb_mem_arbiter.sv
// Framebuffer memory arbiter: display reads have priority, a read-streak limit lets the gfx writer
// through, and idle turnaround cycles are inserted on read/write direction changes.
module fb_mem_arbiter #(
  parameter int unsigned ADDR_WIDTH        = 10,
  parameter int unsigned DATA_WIDTH        = 16,
  parameter int unsigned MAX_RD_STREAK     = 8,
  parameter int unsigned TURNAROUND_CYCLES = 1
) (
  input logic          clk,
  input logic          reset,
  fb_mem_arbiter_if.slave bus
);

  localparam int unsigned STREAK_W = 8;
  localparam int unsigned TURN_W   = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    TURN  = 2'd2
  } state_e;

  typedef enum logic {
    DIR_RD = 1'b0,
    DIR_WR = 1'b1
  } dir_e;

  state_e                state_q, state_d;
  logic                  cmd_valid_q, cmd_valid_d;
  logic                  cmd_we_q, cmd_we_d;
  logic [ADDR_WIDTH-1:0] cmd_addr_q, cmd_addr_d;
  logic [DATA_WIDTH-1:0] cmd_wdata_q, cmd_wdata_d;
  logic [STREAK_W-1:0]   rd_streak_q, rd_streak_d;
  logic [TURN_W-1:0]     turn_cnt_q, turn_cnt_d;
  dir_e                  last_dir_q, last_dir_d;
  dir_e                  target_q, target_d;

  logic slot_free_c;
  logic write_wins_c;
  logic rd_ready_c;
  logic wr_ready_c;
  logic load_rd_c;
  logic load_wr_c;

  assign slot_free_c  = !cmd_valid_q || bus.mem_cmd_ready;
  assign write_wins_c = bus.gfx_wr_valid &&
                        (!bus.disp_rd_valid || (rd_streak_q >= STREAK_W'(MAX_RD_STREAK)));

  // State and command-slot registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cmd_valid_q <= 1'b0;
      cmd_we_q    <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      rd_streak_q <= '0;
      turn_cnt_q  <= '0;
      last_dir_q  <= DIR_RD;
      target_q    <= DIR_RD;
    end else begin
      state_q     <= state_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_we_q    <= cmd_we_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
      rd_streak_q <= rd_streak_d;
      turn_cnt_q  <= turn_cnt_d;
      last_dir_q  <= last_dir_d;
      target_q    <= target_d;
    end
  end

  // Arbitration, turnaround sequencing and slot loading
  always_comb begin
    state_d     = state_q;
    cmd_valid_d = cmd_valid_q;
    cmd_we_d    = cmd_we_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_wdata_d = cmd_wdata_q;
    rd_streak_d = rd_streak_q;
    turn_cnt_d  = turn_cnt_q;
    last_dir_d  = last_dir_q;
    target_d    = target_q;
    rd_ready_c  = 1'b0;
    wr_ready_c  = 1'b0;
    load_rd_c   = 1'b0;
    load_wr_c   = 1'b0;

    // A consumed or empty slot goes idle unless reloaded below
    if (slot_free_c) begin
      cmd_valid_d = 1'b0;
    end

    if (!reset) begin
      case (state_q)
        TURN: begin
          if (turn_cnt_q > TURN_W'(1)) begin
            turn_cnt_d = turn_cnt_q - TURN_W'(1);
          end else begin
            turn_cnt_d = '0;
            state_d    = IDLE;
            if ((target_q == DIR_WR) && bus.gfx_wr_valid) begin
              load_wr_c = 1'b1;
            end else if ((target_q == DIR_RD) && bus.disp_rd_valid) begin
              load_rd_c = 1'b1;
            end
          end
        end
        IDLE, ISSUE: begin
          if (slot_free_c) begin
            state_d = IDLE;
            if (write_wins_c) begin
              if ((last_dir_q == DIR_WR) || (TURNAROUND_CYCLES == 0)) begin
                load_wr_c = 1'b1;
              end else begin
                state_d    = TURN;
                turn_cnt_d = TURN_W'(TURNAROUND_CYCLES);
                target_d   = DIR_WR;
              end
            end else if (bus.disp_rd_valid) begin
              if ((last_dir_q == DIR_RD) || (TURNAROUND_CYCLES == 0)) begin
                load_rd_c = 1'b1;
              end else begin
                state_d    = TURN;
                turn_cnt_d = TURN_W'(TURNAROUND_CYCLES);
                target_d   = DIR_RD;
              end
            end
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase

      if (load_wr_c) begin
        state_d     = ISSUE;
        cmd_valid_d = 1'b1;
        cmd_we_d    = 1'b1;
        cmd_addr_d  = bus.gfx_wr_addr;
        cmd_wdata_d = bus.gfx_wr_data;
        rd_streak_d = '0;
        last_dir_d  = DIR_WR;
        wr_ready_c  = 1'b1;
      end

      if (load_rd_c) begin
        state_d     = ISSUE;
        cmd_valid_d = 1'b1;
        cmd_we_d    = 1'b0;
        cmd_addr_d  = bus.disp_rd_addr;
        cmd_wdata_d = '0;
        last_dir_d  = DIR_RD;
        rd_ready_c  = 1'b1;
        if (rd_streak_q != {STREAK_W{1'b1}}) begin
          rd_streak_d = rd_streak_q + STREAK_W'(1);
        end
      end
    end
  end

  assign bus.mem_cmd_valid = cmd_valid_q;
  assign bus.mem_cmd_we    = cmd_we_q;
  assign bus.mem_cmd_addr  = cmd_addr_q;
  assign bus.mem_cmd_wdata = cmd_wdata_q;
  assign bus.disp_rd_ready = rd_ready_c;
  assign bus.gfx_wr_ready  = wr_ready_c;

  // Read data needs no tagging since only the display issues reads
  assign bus.disp_rd_data_valid = bus.mem_rd_valid && !reset;
  assign bus.disp_rd_data       = reset ? '0 : bus.mem_rd_data;

endmodule

// File: tb/tb_fb_mem_arbiter.sv
// Scoreboard bench for fb_mem_arbiter: stimulus pushes expected commands (with accept cycle) and
// read returns; a negedge monitor pops and compares. u_dut1 runs with zero turnaround.
module tb_fb_mem_arbiter;

  localparam int unsigned AW = 10;
  localparam int unsigned DW = 16;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            cyc;
  } exp_t;

  logic clk;
  logic reset;
  logic sel;
  int   cyc;
  int   n_vec;
  int   n_err;

  logic          rd_valid, wr_valid, cmd_ready, mrd_valid;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [DW-1:0] wr_data, mrd_data;
  logic          ret_pend;
  logic [DW-1:0] ret_data;

  logic          m_valid, m_we, rd_ready, wr_ready, m_rdv;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata;

  exp_t          cmd_q[$];
  logic [DW-1:0] rdq[$];

  fb_mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) b0 ();
  fb_mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) b1 ();

  fb_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_RD_STREAK(8), .TURNAROUND_CYCLES(1))
    u_dut0 (.clk(clk), .reset(reset), .bus(b0));
  fb_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_RD_STREAK(1), .TURNAROUND_CYCLES(0))
    u_dut1 (.clk(clk), .reset(reset), .bus(b1));

  // Only the selected instance sees live inputs; the other idles
  assign b0.disp_rd_valid = rd_valid & ~sel;
  assign b0.disp_rd_addr  = rd_addr;
  assign b0.gfx_wr_valid  = wr_valid & ~sel;
  assign b0.gfx_wr_addr   = wr_addr;
  assign b0.gfx_wr_data   = wr_data;
  assign b0.mem_cmd_ready = cmd_ready & ~sel;
  assign b0.mem_rd_valid  = mrd_valid & ~sel;
  assign b0.mem_rd_data   = mrd_data;
  assign b1.disp_rd_valid = rd_valid & sel;
  assign b1.disp_rd_addr  = rd_addr;
  assign b1.gfx_wr_valid  = wr_valid & sel;
  assign b1.gfx_wr_addr   = wr_addr;
  assign b1.gfx_wr_data   = wr_data;
  assign b1.mem_cmd_ready = cmd_ready & sel;
  assign b1.mem_rd_valid  = mrd_valid & sel;
  assign b1.mem_rd_data   = mrd_data;

  assign m_valid  = sel ? b1.mem_cmd_valid      : b0.mem_cmd_valid;
  assign m_we     = sel ? b1.mem_cmd_we         : b0.mem_cmd_we;
  assign m_addr   = sel ? b1.mem_cmd_addr       : b0.mem_cmd_addr;
  assign m_wdata  = sel ? b1.mem_cmd_wdata      : b0.mem_cmd_wdata;
  assign rd_ready = sel ? b1.disp_rd_ready      : b0.disp_rd_ready;
  assign wr_ready = sel ? b1.gfx_wr_ready       : b0.gfx_wr_ready;
  assign m_rdv    = sel ? b1.disp_rd_data_valid : b0.disp_rd_data_valid;
  assign m_rdata  = sel ? b1.disp_rd_data       : b0.disp_rd_data;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Memory model: data for a read comes back the cycle after the command is accepted
  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return DW'(a) ^ 16'hC3A5;
  endfunction

  initial begin
    mrd_valid = 1'b0;
    mrd_data  = '0;
    forever begin
      @(posedge clk);
      #1;
      mrd_valid = ret_pend;
      mrd_data  = ret_data;
      ret_pend  = 1'b0;
    end
  end

  function automatic void exp_rd(input logic [AW-1:0] a, input int c);
    exp_t e;
    e.we = 1'b0; e.addr = a; e.wdata = '0; e.cyc = c;
    cmd_q.push_back(e);
    rdq.push_back(mem_word(a));
  endfunction

  function automatic void exp_wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input int c);
    exp_t e;
    e.we = 1'b1; e.addr = a; e.wdata = d; e.cyc = c;
    cmd_q.push_back(e);
  endfunction

  // Monitor: compares accepted commands, stall behaviour and read returns
  initial begin : monitor
    exp_t          e;
    logic [DW-1:0] r;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (m_valid && cmd_ready) begin
          n_vec++;
          if (cmd_q.size() == 0) begin
            n_err++;
            $display("FAIL cmd_unexpected: got we=%0b addr=%h at cyc %0d, required none", m_we, m_addr, cyc);
          end else begin
            e = cmd_q.pop_front();
            if (m_we !== e.we || m_addr !== e.addr || (e.we && m_wdata !== e.wdata) || cyc != e.cyc) begin
              n_err++;
              $display("FAIL cmd: got we=%0b addr=%h wdata=%h cyc=%0d, required we=%0b addr=%h wdata=%h cyc=%0d",
                       m_we, m_addr, m_wdata, cyc, e.we, e.addr, e.wdata, e.cyc);
            end
          end
          if (!m_we) begin
            ret_pend = 1'b1;
            ret_data = mem_word(m_addr);
          end
        end
        if (m_valid && !cmd_ready) begin
          n_vec++;
          if (rd_ready !== 1'b0 || wr_ready !== 1'b0) begin
            n_err++;
            $display("FAIL stall_ready: got rd=%0b wr=%0b at cyc %0d, required 0 0", rd_ready, wr_ready, cyc);
          end
        end
        if (m_rdv) begin
          n_vec++;
          if (rdq.size() == 0) begin
            n_err++;
            $display("FAIL rd_return_unexpected: got data=%h at cyc %0d, required none", m_rdata, cyc);
          end else begin
            r = rdq.pop_front();
            if (m_rdata !== r) begin
              n_err++;
              $display("FAIL rd_return: got %h, required %h", m_rdata, r);
            end
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    n_vec++;
    if (got !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, got, req);
    end
  endtask

  task automatic drive_rd(input int n, input logic [AW-1:0] base);
    for (int i = 0; i < n; i++) begin
      logic got;
      got      = 1'b0;
      rd_valid = 1'b1;
      rd_addr  = base + AW'(i);
      for (int k = 0; k < 200 && !got; k++) begin
        @(negedge clk);
        if (rd_ready) got = 1'b1;
        else begin @(posedge clk); #1; end
      end
      if (!got) begin
        n_vec++; n_err++;
        $display("FAIL rd_handshake: got no ready for addr %h, required ready within 200 cycles", rd_addr);
      end
      @(posedge clk);
      #1;
    end
    rd_valid = 1'b0;
  endtask

  task automatic drive_wr(input int n, input logic [AW-1:0] base, input logic [DW-1:0] mask);
    for (int i = 0; i < n; i++) begin
      logic got;
      got      = 1'b0;
      wr_valid = 1'b1;
      wr_addr  = base + AW'(i);
      wr_data  = DW'(wr_addr) ^ mask;
      for (int k = 0; k < 200 && !got; k++) begin
        @(negedge clk);
        if (wr_ready) got = 1'b1;
        else begin @(posedge clk); #1; end
      end
      if (!got) begin
        n_vec++; n_err++;
        $display("FAIL wr_handshake: got no ready for addr %h, required ready within 200 cycles", wr_addr);
      end
      @(posedge clk);
      #1;
    end
    wr_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 300 && (cmd_q.size() != 0 || rdq.size() != 0); k++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (cmd_q.size() != 0 || rdq.size() != 0) begin
      n_err++;
      $display("FAIL %s_drain: got %0d cmds %0d returns pending, required 0 0", name, cmd_q.size(), rdq.size());
      cmd_q.delete();
      rdq.delete();
    end
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    ret_pend = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin : stim
    int s;
    n_vec = 0; n_err = 0;
    sel = 1'b0; reset = 1'b0; ret_pend = 1'b0; ret_data = '0;
    rd_valid = 1'b0; wr_valid = 1'b0; rd_addr = '0; wr_addr = '0; wr_data = '0;
    cmd_ready = 1'b1;

    // Reset state, checked before any clock edge
    #1 reset = 1'b1;
    #2;
    check("rst_cmd_valid", 32'(m_valid), 32'd0);
    check("rst_cmd_we",    32'(m_we),    32'd0);
    check("rst_cmd_addr",  32'(m_addr),  32'd0);
    check("rst_cmd_wdata", 32'(m_wdata), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reads only: one per cycle, first accepted one cycle after the first ready
    @(posedge clk); #1; s = cyc;
    for (int i = 0; i < 16; i++) exp_rd(AW'(i), s + 1 + i);
    drive_rd(16, 10'h000);
    drain("rd_stream");
    do_reset();

    // Both valid: 8 reads, turnaround, 1 write, turnaround, repeat
    @(posedge clk); #1; s = cyc;
    for (int g = 0; g < 3; g++) begin
      for (int j = 0; j < 8; j++) exp_rd(10'h100 + AW'(8 * g + j), s + 1 + 11 * g + j);
      exp_wr(10'h300 + AW'(g), DW'(10'h300 + AW'(g)) ^ 16'hA000, s + 10 + 11 * g);
    end
    fork
      drive_rd(24, 10'h100);
      drive_wr(3, 10'h300, 16'hA000);
    join
    drain("mixed");
    do_reset();

    // Writes only after reset: one turnaround cycle first, then one per cycle
    @(posedge clk); #1; s = cyc;
    for (int i = 0; i < 32; i++) exp_wr(10'h200 + AW'(i), DW'(10'h200 + AW'(i)), s + 2 + i);
    drive_wr(32, 10'h200, 16'h0000);
    drain("wr_stream");
    do_reset();

    // Memory stall for 5 cycles with a read loaded and another pending
    @(posedge clk); #1; s = cyc;
    exp_rd(10'h050, s + 6);
    exp_rd(10'h051, s + 7);
    cmd_ready = 1'b0;
    fork
      drive_rd(2, 10'h050);
      begin
        repeat (6) @(posedge clk);
        #1 cmd_ready = 1'b1;
      end
    join
    drain("stall");
    do_reset();

    // Reset mid-operation with rd_streak at 5 and a command still in the slot
    @(posedge clk); #1; s = cyc;
    for (int i = 0; i < 4; i++) exp_rd(10'h0A0 + AW'(i), s + 1 + i);
    fork
      drive_rd(5, 10'h0A0);
      begin
        repeat (5) @(posedge clk);
        #1 cmd_ready = 1'b0;
      end
    join
    #5;
    reset    = 1'b1;
    ret_pend = 1'b0;
    rd_valid = 1'b1;
    wr_valid = 1'b1;
    #1;
    check("async_rst_cmd_valid", 32'(m_valid),  32'd0);
    check("async_rst_rd_ready",  32'(rd_ready), 32'd0);
    check("async_rst_wr_ready",  32'(wr_ready), 32'd0);
    @(posedge clk); #1;
    check("rst_hold_cmd_valid",  32'(m_valid),  32'd0);
    check("rst_hold_wr_ready",   32'(wr_ready), 32'd0);
    rd_valid = 1'b0; wr_valid = 1'b0; cmd_ready = 1'b1;
    reset = 1'b0;
    drain("rst_mid");

    // After reset the streak restarts at 0 and the first write still needs a turnaround
    @(posedge clk); #1; s = cyc;
    for (int j = 0; j < 8; j++) exp_rd(10'h0C0 + AW'(j), s + 1 + j);
    exp_wr(10'h3F0, DW'(10'h3F0) ^ 16'h0F0F, s + 10);
    fork
      drive_rd(8, 10'h0C0);
      drive_wr(1, 10'h3F0, 16'h0F0F);
    join
    drain("post_rst");

    // Zero-turnaround instance with streak limit 1: strict read/write alternation, no gaps
    sel = 1'b1;
    do_reset();
    @(posedge clk); #1; s = cyc;
    for (int i = 0; i < 4; i++) begin
      exp_rd(10'h110 + AW'(i), s + 1 + 2 * i);
      exp_wr(10'h210 + AW'(i), DW'(10'h210 + AW'(i)) ^ 16'h00F0, s + 2 + 2 * i);
    end
    fork
      drive_rd(4, 10'h110);
      drive_wr(4, 10'h210, 16'h00F0);
    join
    drain("no_turn");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
